jkc_seq_checker: RTL
====================

JKC_SEQ_CHECKER -- requirements
Module: jkc_seq_checker

Interface
REQ-001 SHALL have parameter LOCK_LEN, default 4, meaning the number of consecutive correct transitions needed to declare lock (legal range 1..15).
REQ-002 SHALL have parameter UP, default 1, meaning the expected count direction (1 = increment mod 8, 0 = decrement mod 8).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports Q0, Q1, Q2, input, 1 bit each: the count bits from the upstream 3-bit JK counter, synchronous to clk; Q2 is the MSB.
REQ-006 SHALL have ports Q0n, Q1n, Q2n, input, 1 bit each: the complement outputs of the upstream counter.
REQ-007 SHALL have port en, input, 1 bit: sample enable; when low, no sample is taken and no state changes.
REQ-008 SHALL have port count_out, output, 3 bits: the last accepted sample {Q2,Q1,Q0}.
REQ-009 SHALL have port locked, output, 1 bit: high while the FSM is in LOCKED.
REQ-010 SHALL have port err_pulse, output, 1 bit: a one-cycle pulse on each detected error.
REQ-011 SHALL have port err_sticky, output, 1 bit: set by any error and cleared only by reset.
REQ-012 SHALL have port wrap_cnt, output, 8 bits: the number of wraps seen while locked (7->0 when UP=1, 0->7 when UP=0); wraps modulo 256.
REQ-013 SHALL have port err_cnt, output, 8 bits: the number of errors, saturating at 255.

Function
REQ-014 On each rising clk edge with en=1, the block SHALL sample cur={Q2,Q1,Q0}, register it into count_out, and hold the previous sample in prev.
REQ-015 A sample SHALL be a complement error if any Qi equals its Qin.
REQ-016 A sample SHALL be a sequence error if prev_valid=1 and cur != prev+1 mod 8 (UP=1) or cur != prev-1 mod 8 (UP=0).
REQ-017 prev_valid SHALL be 0 after reset and SHALL become 1 after the first enabled sample; the first sample SHALL never raise a sequence error.
REQ-018 The FSM SHALL have the states IDLE, SEARCH and LOCKED.
REQ-019 IDLE -> SEARCH SHALL occur on the first enabled sample, with run=0.
REQ-020 In SEARCH, a correct transition SHALL increment run, and reaching run=LOCK_LEN SHALL go to LOCKED in the same edge, so locked rises the cycle after the LOCK_LEN-th correct transition.
REQ-021 In SEARCH, any error SHALL set run=0 and keep the FSM in SEARCH.
REQ-022 In LOCKED, any error SHALL go to SEARCH with run=0.
REQ-023 err_pulse SHALL assert for exactly one cycle, registered, the cycle after an errored sample.
REQ-024 err_pulse SHALL assert only for errors detected in LOCKED, or for complement errors in any state; sequence errors in SEARCH SHALL only reset run.
REQ-025 Each err_pulse SHALL increment err_cnt (saturating) and set err_sticky.
REQ-026 A sample with both a complement error and a sequence error SHALL count as one error.
REQ-027 wrap_cnt SHALL increment only on a correct wrap transition while in LOCKED; the transition that enters LOCKED SHALL also count if it is a wrap.
REQ-028 With en=0, all registers SHALL hold and err_pulse SHALL be 0.
REQ-029 A gap in en SHALL not itself be an error; the next enabled sample SHALL be compared against the last accepted prev.

Reset
REQ-030 While rst_n=0, the block SHALL asynchronously force: FSM=IDLE, run=0, prev=0, prev_valid=0, count_out=3'b000, locked=0, err_pulse=0, err_sticky=0, wrap_cnt=0, err_cnt=0.
REQ-031 Reset asserted mid-operation SHALL abandon lock immediately; after release, relock SHALL require LOCK_LEN fresh correct transitions.
REQ-032 Release of rst_n SHALL be treated as synchronous to clk; no sample SHALL be taken on the edge coincident with release.

Structure
REQ-033 The FSM state enumeration (IDLE, SEARCH, LOCKED) and the counter widths (CNT_W=3, STAT_W=8) SHALL reside in the shared package jkc_pkg.
REQ-034 The next-expected-value and error-classification logic SHALL be one combinational sub-module, jkc_seq_cmp (inputs prev, cur, complements, UP; outputs seq_err, cmp_err, wrap); all registers SHALL stay in the top module.

Verification
REQ-035 Reset, then a clean count 0,1,2,...,7,0,1,... with en=1 and LOCK_LEN=4 -> locked rises one cycle after the sample of value 4; err_cnt stays 0; wrap_cnt=1 after the 7->0 sample.
REQ-036 While locked, force the sample sequence 3,5 -> one err_pulse, err_cnt=1, err_sticky=1, locked falls; relock after 4 further correct transitions.
REQ-037 Force Q1n=Q1 for one sample while locked -> exactly one err_pulse, err_cnt incremented by 1, FSM returns to SEARCH.
REQ-038 Drop en for 3 cycles while the upstream counter keeps running, then restore it -> sequence error detected on the first re-enabled sample (prev stale); with the counter also frozen during the gap -> no error.
REQ-039 Inject 300 errors -> err_cnt saturates at 255; 260 locked wraps -> wrap_cnt=4.
REQ-040 Assert rst_n=0 mid-lock, asynchronously between clock edges -> all outputs reach their reset values before the next clock edge; after release, the first sample raises no error.

Source files
------------

// File: rtl/jkc_pkg.sv
// Shared types and widths for the JK-counter sequence checker.
package jkc_pkg;

    localparam int CNT_W  = 3;
    localparam int STAT_W = 8;
    localparam int RUN_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } jkc_state_t;

endpackage

// File: rtl/jkc_seq_cmp.sv
// Combinational classifier: complement check, next-expected comparison and wrap detection.
module jkc_seq_cmp
    import jkc_pkg::*;
#(
    parameter int unsigned UP = 1
) (
    input  logic [CNT_W-1:0] prev,
    input  logic             prev_valid,
    input  logic [CNT_W-1:0] cur,
    input  logic [CNT_W-1:0] curn,
    output logic             seq_err,
    output logic             cmp_err,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] ALL_ONES  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] ALL_ZEROS = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] WRAP_FROM = (UP != 0) ? ALL_ONES : ALL_ZEROS;
    localparam logic [CNT_W-1:0] WRAP_TO   = (UP != 0) ? ALL_ZEROS : ALL_ONES;

    logic [CNT_W-1:0] same_bits;
    logic [CNT_W-1:0] expected;

    // A healthy flop always drives Q and Qn to opposite levels.
    generate
        for (genvar gi = 0; gi < CNT_W; gi++) begin : g_cmp
            assign same_bits[gi] = ~(cur[gi] ^ curn[gi]);
        end
    endgenerate

    assign expected = (UP != 0) ? (prev + CNT_W'(1)) : (prev - CNT_W'(1));
    assign cmp_err  = |same_bits;
    assign seq_err  = prev_valid && (cur != expected);
    assign wrap     = prev_valid && (prev == WRAP_FROM) && (cur == WRAP_TO);

endmodule

// File: rtl/jkc_seq_checker.sv
// Lock/error monitor for an upstream 3-bit JK counter: tracks consecutive correct
// transitions, declares lock, and keeps error and wrap statistics.
module jkc_seq_checker
    import jkc_pkg::*;
#(
    parameter int          LOCK_LEN = 4,
    parameter int unsigned UP       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Q0,
    input  logic              Q1,
    input  logic              Q2,
    input  logic              Q0n,
    input  logic              Q1n,
    input  logic              Q2n,
    input  logic              en,
    output logic [CNT_W-1:0]  count_out,
    output logic              locked,
    output logic              err_pulse,
    output logic              err_sticky,
    output logic [STAT_W-1:0] wrap_cnt,
    output logic [STAT_W-1:0] err_cnt
);

    localparam logic [RUN_W-1:0]  LOCK_LEN_C = RUN_W'(LOCK_LEN);
    localparam logic [STAT_W-1:0] STAT_MAX   = {STAT_W{1'b1}};

    jkc_state_t        state_reg, state_next;
    logic [RUN_W-1:0]  run_reg, run_next;
    logic [CNT_W-1:0]  prev_reg;
    logic              prev_valid_reg;
    logic              err_pulse_reg, err_pulse_next;
    logic              err_sticky_reg;
    logic [STAT_W-1:0] wrap_cnt_reg;
    logic [STAT_W-1:0] err_cnt_reg;
    logic              wrap_inc;

    logic [CNT_W-1:0]  cur;
    logic [CNT_W-1:0]  curn;
    logic              seq_err;
    logic              cmp_err;
    logic              wrap;
    logic              any_err;
    logic [RUN_W-1:0]  run_inc;

    assign cur     = {Q2, Q1, Q0};
    assign curn    = {Q2n, Q1n, Q0n};
    assign any_err = seq_err | cmp_err;
    assign run_inc = run_reg + RUN_W'(1);

    jkc_seq_cmp #(
        .UP (UP)
    ) u_cmp (
        .prev       (prev_reg),
        .prev_valid (prev_valid_reg),
        .cur        (cur),
        .curn       (curn),
        .seq_err    (seq_err),
        .cmp_err    (cmp_err),
        .wrap       (wrap)
    );

    // Sequence errors while searching only restart the run; they are not reported.
    always_comb begin
        state_next     = state_reg;
        run_next       = run_reg;
        err_pulse_next = 1'b0;
        wrap_inc       = 1'b0;
        if (en) begin
            case (state_reg)
                IDLE: begin
                    state_next     = SEARCH;
                    run_next       = '0;
                    err_pulse_next = cmp_err;
                end
                SEARCH: begin
                    if (any_err) begin
                        run_next       = '0;
                        err_pulse_next = cmp_err;
                    end else if (run_inc == LOCK_LEN_C) begin
                        state_next = LOCKED;
                        run_next   = '0;
                        wrap_inc   = wrap;
                    end else begin
                        run_next = run_inc;
                    end
                end
                LOCKED: begin
                    if (any_err) begin
                        state_next     = SEARCH;
                        run_next       = '0;
                        err_pulse_next = 1'b1;
                    end else begin
                        wrap_inc = wrap;
                    end
                end
                default: begin
                    state_next = IDLE;
                    run_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            run_reg   <= '0;
        end else begin
            state_reg <= state_next;
            run_reg   <= run_next;
        end
    end

    // The last accepted sample doubles as the comparison reference for the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_reg       <= '0;
            prev_valid_reg <= 1'b0;
        end else if (en) begin
            prev_reg       <= cur;
            prev_valid_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_pulse_reg  <= 1'b0;
            err_sticky_reg <= 1'b0;
            err_cnt_reg    <= '0;
            wrap_cnt_reg   <= '0;
        end else begin
            err_pulse_reg <= err_pulse_next;
            if (err_pulse_next) begin
                err_sticky_reg <= 1'b1;
                if (err_cnt_reg != STAT_MAX) begin
                    err_cnt_reg <= err_cnt_reg + STAT_W'(1);
                end
            end
            if (wrap_inc) begin
                wrap_cnt_reg <= wrap_cnt_reg + STAT_W'(1);
            end
        end
    end

    assign count_out  = prev_reg;
    assign locked     = (state_reg == LOCKED);
    assign err_pulse  = err_pulse_reg;
    assign err_sticky = err_sticky_reg;
    assign wrap_cnt   = wrap_cnt_reg;
    assign err_cnt    = err_cnt_reg;

endmodule
